clk_div_prog: RTL and testbench

Programmable clock-enable / divided-clock generator: successor to the fixed free-running-counter divider. Derives a single-cycle `tick` strobe and a 50 % duty square wave `sq` from `clk`, with a runtime-loadable divide ratio, a count enable and glitch-free ratio changes. It sits next to the board clock and feeds slow logic such as LED blinkers, debouncers and display multiplexers.

---
 rtl/clk_div_prog.sv | 115 +++++++++++
 tb/tb_clk_div_prog.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Programmable clock-enable and divided-clock generator. A phase counter runs
// from 0 to N-1 while `en` is high. Each time it wraps, the block emits a
// one-cycle `tick` and toggles the 50 % duty square wave `sq`. The divide
// ratio N can be changed at run time. A new ratio is only applied on a wrap
// edge, so no period is ever cut short or stretched.
//
// Parameters
//   WIDTH        counter and divisor width in bits
//   DEFAULT_DIV  divisor loaded by reset (1 .. 2^WIDTH-1)
//
// Ports
//   clk     in   system clock; all logic runs on its rising edge
//   rst     in   synchronous, active-high reset
//   en      in   count enable; when low the phase freezes
//   load    in   one-cycle strobe that captures div_in
//   div_in  in   new divisor N (0 is treated as 1)
//   tick    out  one-cycle pulse at each period boundary (registered)
//   sq      out  square wave, toggles at each period boundary (registered)
//   cnt     out  current phase count, 0 .. N-1 (registered)
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int WIDTH       = 23,
    parameter int DEFAULT_DIV = 4194304
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             sq,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Active divisor, plus a one-deep pending slot for a ratio that arrives
    // mid-period.
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             pend_v;

    // A requested divisor of 0 would never wrap, so it is clamped to 1.
    logic [WIDTH-1:0] div_load;
    assign div_load = (div_in == '0) ? ONE : div_in;

    // div_act is always at least 1, so div_act - 1 cannot underflow.
    logic wrap;
    assign wrap = en && (cnt == div_act - ONE);

    // Next-state values
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] div_act_nxt;
    logic [WIDTH-1:0] div_pend_nxt;
    logic             pend_v_nxt;
    logic             tick_nxt;
    logic             sq_nxt;

    always_comb begin
        cnt_nxt      = cnt;
        div_act_nxt  = div_act;
        div_pend_nxt = div_pend;
        pend_v_nxt   = pend_v;
        tick_nxt     = 1'b0;
        sq_nxt       = sq;

        if (wrap) begin
            cnt_nxt  = '0;
            tick_nxt = 1'b1;
            sq_nxt   = ~sq;
            // A load that lands on the wrap edge governs the period that
            // starts here. It takes priority over an older pending value.
            if (load) begin
                div_act_nxt = div_load;
                pend_v_nxt  = 1'b0;
            end else if (pend_v) begin
                div_act_nxt = div_pend;
                pend_v_nxt  = 1'b0;
            end
        end else begin
            if (en) begin
                cnt_nxt = cnt + ONE;
            end
            // Loads are accepted even while counting is frozen. When several
            // loads arrive before a wrap, the last one wins.
            if (load) begin
                div_pend_nxt = div_load;
                pend_v_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_act  <= DIV_RST;
            div_pend <= DIV_RST;
            pend_v   <= 1'b0;
            tick     <= 1'b0;
            sq       <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_act  <= div_act_nxt;
            div_pend <= div_pend_nxt;
            pend_v   <= pend_v_nxt;
            tick     <= tick_nxt;
            sq       <= sq_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
//
// Bench for clk_div_prog with WIDTH=8 and DEFAULT_DIV=5.
//
// The reference model tracks the active period length, the position inside
// that period, and an optional pending ratio. Each clock edge appends the
// expected {tick, sq, cnt} to exp_q. A separate monitor pops each entry on the
// falling edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int W   = 8;
    localparam int DEF = 5;

    // ---------------- clock / reset block ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         tick;
    logic         sq;
    logic [W-1:0] cnt;

    always #5 clk = ~clk;

    clk_div_prog #(
        .WIDTH      (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .div_in(div_in),
        .tick  (tick),
        .sq    (sq),
        .cnt   (cnt)
    );

    // ---------------- reference model ----------------
    // m_len  : length of the period currently being counted
    // m_pos  : enabled cycles already spent in that period
    // m_next : ratio waiting for the next boundary, 0 when none
    int m_len = DEF;
    int m_pos = 0;
    int m_next = 0;
    bit m_sq = 1'b0;
    bit m_tick = 1'b0;

    task automatic model_step(input bit r, input bit e, input bit l, input int d);
        int req;
        req = (d == 0) ? 1 : d;
        if (r) begin
            m_len = DEF; m_pos = 0; m_next = 0; m_sq = 1'b0; m_tick = 1'b0;
            return;
        end
        m_tick = 1'b0;
        if (e && (m_pos + 1 == m_len)) begin
            // period complete: a new period starts now
            m_pos  = 0;
            m_tick = 1'b1;
            m_sq   = !m_sq;
            if (l) begin
                m_len = req; m_next = 0;
            end else if (m_next != 0) begin
                m_len = m_next; m_next = 0;
            end
        end else begin
            if (e) m_pos = m_pos + 1;
            if (l) m_next = req;
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        logic [W+1:0] exp_v;
        logic [W+1:0] act_v;
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {tick, sq, cnt};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t got tick=%b sq=%b cnt=%0d expected tick=%b sq=%b cnt=%0d",
                         $time, act_v[W+1], act_v[W], act_v[W-1:0],
                         exp_v[W+1], exp_v[W], exp_v[W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit r, input bit e, input bit l, input int d);
        int pos_v;
        rst    = r;
        en     = e;
        load   = l;
        div_in = W'(d);
        model_step(r, e, l, d);
        @(posedge clk);
        pos_v = m_pos;
        exp_q.push_back({m_tick, m_sq, pos_v[W-1:0]});
        #1;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 0);
    endtask

    // Count enabled cycles until the model sits at phase ph of an N=len
    // period (len=0 accepts any length).
    task automatic run_until(input int ph, input int len);
        int guard;
        guard = 0;
        while (!(m_pos == ph && (len == 0 || m_len == len)) && guard < 400) begin
            drive(1'b0, 1'b1, 1'b0, 0);
            guard++;
        end
        checks++;
        if (guard >= 400) begin
            errors++;
            $display("FAIL run_until got phase=%0d len=%0d expected phase=%0d len=%0d",
                     m_pos, m_len, ph, len);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset defaults: reset held for 2 cycles, then counting
        drive(1'b1, 1'b0, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 9);       // reset overrides en and load
        run(16);                          // ticks at cycles 5, 10, 15

        // divide by 4: load at cnt=1 while N=5
        run_until(1, 5);
        drive(1'b0, 1'b1, 1'b1, 4);
        run(20);

        // coincident load on the wrap cycle
        run_until(3, 4);
        drive(1'b0, 1'b1, 1'b1, 3);
        run(10);

        // zero behaves as N=1, then N=2
        drive(1'b0, 1'b1, 1'b1, 0);
        run(8);
        drive(1'b0, 1'b1, 1'b1, 2);
        run(8);

        // enable gating at cnt=3 with N=6; a load while frozen is still accepted
        drive(1'b0, 1'b1, 1'b1, 6);
        run_until(3, 6);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 0);
        run(14);
        drive(1'b0, 1'b0, 1'b1, 4);
        run(10);

        // last write wins among several mid-period loads
        run_until(1, 0);
        drive(1'b0, 1'b1, 1'b1, 9);
        drive(1'b0, 1'b1, 1'b1, 2);
        run(12);

        // mid-operation reset discards a pending divisor
        run_until(0, 2);
        drive(1'b0, 1'b1, 1'b1, 7);
        drive(1'b1, 1'b1, 1'b0, 0);
        run(12);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            bit r, e, l;
            int d;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) < 8);
            l = ($urandom_range(0, 14) == 0);
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 9);
            drive(r, e, l, d);
        end

        // Let the monitor drain the last expectations.
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
